mem_port_arbiter: RTL

Shares the single-port unified memory of the RV32I core among three requesters: instruction fetch, load/store, and the test read port. It sits between the datapath's memory interfaces and the memory macro. It enforces one outstanding access at a time and returns read data with a fixed latency. It also blocks fetches while the core is halted and prevents fetch starvation under continuous load/store traffic.

---
 rtl/rv_mem_pkg.sv | 45 ++++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   owner_t     : which requester owns the outstanding access
//   arb_state_t : arbiter FSM states
//   REQ_*       : bit positions of each requester in eligibility/grant vectors
package rv_mem_pkg;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerIf   = 2'd1,
        OwnerLs   = 2'd2,
        OwnerTst  = 2'd3
    } owner_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } arb_state_t;

    // Legal parameter ranges.
    localparam int unsigned LAT_MIN        = 1;
    localparam int unsigned LAT_MAX        = 4;
    localparam int unsigned STARVE_MAX_MIN = 1;
    localparam int unsigned STARVE_MAX_MAX = 15;

    // lat_cnt holds at most LAT_MAX-1.
    localparam int unsigned LAT_CNT_W = 2;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_IF  = 0;
    localparam int unsigned REQ_LS  = 1;
    localparam int unsigned REQ_TST = 2;

    function automatic owner_t onehot_to_owner(input logic [NUM_REQ-1:0] oh);
        owner_t o;
        o = OwnerNone;
        unique case (oh)
            3'b001:  o = OwnerIf;
            3'b010:  o = OwnerLs;
            3'b100:  o = OwnerTst;
            default: o = OwnerNone;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory port arbiter.
//   elig   : per-requester eligibility (bit positions REQ_IF/REQ_LS/REQ_TST)
//   starve : fetch has waited the maximum number of load/store grants
//   gnt    : one-hot winner, all zero when nobody is eligible
module mem_arb_pick
    import rv_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  logic               starve,
    output logic [NUM_REQ-1:0] gnt
);

    // TST over LS over IF, except a starved fetch jumps ahead of LS.
    always_comb begin
        gnt = '0;
        if (elig[REQ_TST]) begin
            gnt[REQ_TST] = 1'b1;
        end else if (starve && elig[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end else if (elig[REQ_LS]) begin
            gnt[REQ_LS] = 1'b1;
        end else if (elig[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory among fetch, load/store and test-read requesters.
// One access outstanding at a time; read data returns LAT cycles after grant.
//   clk, rst (async, active low), hlt (blocks new fetch grants)
//   if_*  : fetch port        (req/addr in, gnt/rvalid out)
//   ls_*  : load/store port   (req/we/addr/wdata/wmask in, gnt/rvalid out)
//   tst_* : test read port    (req/addr in, gnt/rvalid out)
//   rdata : read data, qualified by the owner's rvalid
//   mem_* : memory macro side
//   busy  : an access is outstanding
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_wmask,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    input  logic              tst_req,
    input  logic [ADDR_W-1:0] tst_addr,
    output logic              tst_gnt,
    output logic              tst_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

    arb_state_t           state_q, state_d;
    owner_t               owner_q, owner_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [SC_W-1:0]      starve_cnt_q, starve_cnt_d;

    logic               done;
    logic               grant_ok;
    logic               if_elig;
    logic               starve;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt;
    owner_t             winner;

    // Final WAIT cycle: the outstanding access completes and the port is free again.
    assign done     = (state_q == StWait) && (lat_cnt_q == '0);
    // Gating with rst keeps every grant and mem_en low while reset is held.
    assign grant_ok = rst && ((state_q == StIdle) || done);
    assign if_elig  = if_req && !hlt;
    assign starve   = (starve_cnt_q == SC_W'(STARVE_MAX));

    always_comb begin
        elig          = '0;
        elig[REQ_IF]  = if_elig;
        elig[REQ_LS]  = ls_req;
        elig[REQ_TST] = tst_req;
    end

    mem_arb_pick u_pick (
        .elig   (elig),
        .starve (starve),
        .gnt    (pick)
    );

    assign gnt    = grant_ok ? pick : '0;
    assign winner = onehot_to_owner(gnt);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnerNone;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (winner != OwnerNone) begin
                    state_d   = StWait;
                    owner_d   = winner;
                    lat_cnt_d = LAT_CNT_W'(LAT - 1);
                end
            end
            StWait: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                end else if (winner != OwnerNone) begin
                    // Back-to-back: stay in WAIT with the new owner.
                    owner_d   = winner;
                    lat_cnt_d = LAT_CNT_W'(LAT - 1);
                end else begin
                    state_d   = StIdle;
                    owner_d   = OwnerNone;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnerNone;
            end
        endcase

        // Counts LS grants that bypass a waiting fetch; only moves on a grant.
        if (winner != OwnerNone) begin
            if (gnt[REQ_LS] && if_elig) begin
                if (!starve) begin
                    starve_cnt_d = starve_cnt_q + SC_W'(1);
                end
            end else if (gnt[REQ_IF] || !if_elig) begin
                starve_cnt_d = '0;
            end
        end
    end

    // Outputs.
    always_comb begin
        if_gnt     = gnt[REQ_IF];
        ls_gnt     = gnt[REQ_LS];
        tst_gnt    = gnt[REQ_TST];
        if_rvalid  = done && (owner_q == OwnerIf);
        ls_rvalid  = done && (owner_q == OwnerLs);
        tst_rvalid = done && (owner_q == OwnerTst);
        rdata      = done ? mem_rdata : '0;
        busy       = (state_q == StWait);

        mem_en     = |gnt;
        mem_we     = gnt[REQ_LS] && ls_we;
        mem_addr   = ls_addr;
        if (gnt[REQ_TST]) begin
            mem_addr = tst_addr;
        end else if (gnt[REQ_IF]) begin
            mem_addr = if_addr;
        end
        mem_wdata  = ls_wdata;
        mem_wmask  = ls_wmask;
    end

endmodule
